// File: rtl/cascade_counter_chain_if.sv
// Bus between the cascade counter chain and its user: control inputs, load data,
// chain value and the terminal-count / wrap status.
interface cascade_counter_chain_if #(
  parameter int STAGE_WIDTH = 16,
  parameter int NUM_STAGES  = 4
);
  localparam int TOTAL_WIDTH = STAGE_WIDTH * NUM_STAGES;

  logic                   clear;
  logic                   enable;
  logic                   up;
  logic                   load;
  logic [TOTAL_WIDTH-1:0] load_value;
  logic                   sticky_clear;
  logic [TOTAL_WIDTH-1:0] count;
  logic [NUM_STAGES-1:0]  stage_tc;
  logic                   wrap;
  logic                   wrap_sticky;

  modport master (
    output clear, enable, up, load, load_value, sticky_clear,
    input  count, stage_tc, wrap, wrap_sticky
  );

  modport slave (
    input  clear, enable, up, load, load_value, sticky_clear,
    output count, stage_tc, wrap, wrap_sticky
  );
endinterface

// File: rtl/cascade_counter_chain.sv
// NUM_STAGES-digit, base-STAGE_MODULUS up/down counter built from cascaded digit
// stages with a single-cycle combinational carry ripple, load/clear and wrap status.
module cascade_counter_chain #(
  parameter int STAGE_WIDTH   = 16,
  parameter int NUM_STAGES    = 4,
  parameter int STAGE_MODULUS = 2 ** STAGE_WIDTH
) (
  input  logic clk,
  input  logic reset,
  cascade_counter_chain_if.slave bus
);
  localparam int TOTAL_WIDTH = STAGE_WIDTH * NUM_STAGES;
  localparam logic [STAGE_WIDTH-1:0] MAX_DIGIT = STAGE_WIDTH'(STAGE_MODULUS - 1);
  localparam logic [STAGE_WIDTH-1:0] DIGIT_ONE = STAGE_WIDTH'(1);
  // Clamp compare is done one bit wider so it stays meaningful when MAX_DIGIT is all ones.
  localparam logic [STAGE_WIDTH:0]   MAX_WIDE  = (STAGE_WIDTH + 1)'(STAGE_MODULUS - 1);

  logic [TOTAL_WIDTH-1:0] count_q;
  logic                   wrap_q;
  logic                   wrap_sticky_q;

  logic [TOTAL_WIDTH-1:0] step_count;
  logic [TOTAL_WIDTH-1:0] load_clamped;
  logic [NUM_STAGES-1:0]  tc;
  logic                   wrap_event;
  logic                   ripple;
  logic [STAGE_WIDTH-1:0] digit;
  logic [STAGE_WIDTH-1:0] ld_digit;

  // Carry ripples from stage 0 upward; a stage steps only while every lower stage is terminal.
  always_comb begin
    step_count   = count_q;
    load_clamped = '0;
    tc           = '0;
    ripple       = bus.enable;
    digit        = '0;
    ld_digit     = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      digit = count_q[i*STAGE_WIDTH +: STAGE_WIDTH];
      tc[i] = (digit == (bus.up ? MAX_DIGIT : '0));
      if (ripple) begin
        if (bus.up)
          step_count[i*STAGE_WIDTH +: STAGE_WIDTH] = (digit == MAX_DIGIT) ? '0 : digit + DIGIT_ONE;
        else
          step_count[i*STAGE_WIDTH +: STAGE_WIDTH] = (digit == '0) ? MAX_DIGIT : digit - DIGIT_ONE;
      end
      ripple   = ripple & tc[i];
      ld_digit = bus.load_value[i*STAGE_WIDTH +: STAGE_WIDTH];
      load_clamped[i*STAGE_WIDTH +: STAGE_WIDTH] =
        ({1'b0, ld_digit} > MAX_WIDE) ? MAX_DIGIT : ld_digit;
    end
    wrap_event = ripple;
  end

  // Priority is reset > clear > load > counting; a wrap sets the sticky flag even against sticky_clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      wrap_q        <= 1'b0;
      wrap_sticky_q <= 1'b0;
    end else if (bus.clear) begin
      count_q       <= '0;
      wrap_q        <= 1'b0;
      wrap_sticky_q <= 1'b0;
    end else if (bus.load) begin
      count_q       <= load_clamped;
      wrap_q        <= 1'b0;
    end else begin
      count_q <= step_count;
      wrap_q  <= wrap_event;
      if (wrap_event)
        wrap_sticky_q <= 1'b1;
      else if (bus.sticky_clear)
        wrap_sticky_q <= 1'b0;
    end
  end

  assign bus.count       = count_q;
  assign bus.stage_tc    = tc;
  assign bus.wrap        = wrap_q;
  assign bus.wrap_sticky = wrap_sticky_q;
endmodule

// File: doc/cascade_counter_chain.md
# cascade_counter_chain

Parametrised cascade of modulo-M digit counters. Every stage advances only when all lower stages sit at their terminal value, so the full chain behaves as one NUM_STAGES-digit, base-STAGE_MODULUS counter. The block adds up/down counting, synchronous load and clear, per-stage terminal-count flags, and wrap reporting. It is the general-purpose successor to the fixed up-only counter chain and serves as a timer/event counter or as a fitter stress load.

## Interface
- STAGE_WIDTH, 16, bits per stage digit.
- NUM_STAGES, 4, number of cascaded stages, 1..64.
- STAGE_MODULUS, 2**STAGE_WIDTH, digit range 0..STAGE_MODULUS-1; legal range 2..2**STAGE_WIDTH (10 gives BCD).
- TOTAL_WIDTH (localparam), STAGE_WIDTH*NUM_STAGES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous clear of count and flags.
- enable  in  1  count enable for stage 0.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load.
- load_value  in  TOTAL_WIDTH  load data; digit i is bits [i*STAGE_WIDTH +: STAGE_WIDTH].
- count  out  TOTAL_WIDTH  registered chain value, same digit packing.
- stage_tc  out  NUM_STAGES  combinational; bit i = digit i is at its terminal value for the current direction.
- wrap  out  1  registered one-cycle pulse: the chain wrapped on the previous edge.
- wrap_sticky  out  1  registered; set by wrap, held until cleared.
- sticky_clear  in  1  synchronous clear of wrap_sticky.

## Operation
- Terminal value: STAGE_MODULUS-1 when up=1, 0 when up=0. stage_tc[i] = (digit i == terminal). It follows up and count combinationally.
- Carry-in: carry[0] = enable; carry[i] = carry[i-1] & stage_tc[i-1]. Stage i steps when carry[i]=1.
- Up step: digit == MOD-1 goes to 0, else digit+1. Down step: digit == 0 goes to MOD-1, else digit-1.
- Chain wrap event: carry[NUM_STAGES-1] & stage_tc[NUM_STAGES-1] while a step is taken.
  - Up: all digits MOD-1 go to all 0.
  - Down: all 0 go to all MOD-1.
- Priority per edge: reset > clear > load > enable.
  - clear: count=0, wrap=0, wrap_sticky=0.
  - load: each digit = min(load_value digit, MOD-1). wrap=0; wrap_sticky unchanged.
  - enable=0 with no load/clear: count holds and wrap=0.
- wrap_sticky: if a wrap event occurs, set to 1. Else if sticky_clear, set to 0. Else hold. Set wins over a simultaneous sticky_clear. clear overrides both.
- Changing up takes effect on the next edge. No illegal digit values are reachable after reset, clear, or load.

## Timing
- Reset values (asynchronous, immediate): count=0, wrap=0, wrap_sticky=0. stage_tc then reflects count=0: all ones if up=0, all zeros if up=1 and MOD>1.
- Latency: an input sampled at edge k is reflected in count after edge k. wrap goes high for exactly the cycle after the wrapping edge. wrap_sticky rises on that same edge.
- A reset asserted mid-count clears all registers within the cycle regardless of clk. Counting resumes on the first edge after reset deasserts, if enable=1.
- Carry is a combinational ripple across all stages in one cycle: the critical path scales with NUM_STAGES. No pipelining.
- enable held high for MOD**NUM_STAGES cycles returns count to its start value with exactly one wrap pulse.

## Test plan
Parameters for all scenarios: STAGE_WIDTH=4, NUM_STAGES=3, STAGE_MODULUS=10 (BCD).
1. Load 0x099, up=1, one enable cycle -> count=0x100. stage_tc was 3'b011 before the edge and is 3'b000 after. wrap stays 0.
2. Load 0x999, up=1, enable one cycle -> count=0x000, wrap=1 for one cycle, wrap_sticky=1. A further enable cycle gives count=0x001 and wrap=0.
3. After reset, up=0, enable one cycle -> count=0x999 and wrap pulse. Then three cycles -> 0x996. Then enable=0 for five cycles -> holds 0x996.
4. load_value=0x5AF with load=1, clear=0 -> count=0x599 (digits clamped). Then clear=1, load=1, enable=1 together -> count=0x000, wrap_sticky=0.
5. With wrap_sticky=1, assert sticky_clear on the same edge as a new 0x999->0x000 wrap -> wrap_sticky stays 1. sticky_clear alone on the next edge -> 0.
6. Count up from 0x000 and assert reset asynchronously mid-cycle at 0x123 -> count=0x000 before the next edge. After release, enable=1 continuous gives 0x001 on the first edge; 1000 edges total from 0x000 yield exactly one wrap.
